// File: rtl/branch_resolution_tracker_pkg.sv
// Shared types for the branch resolution tracker: occupancy FSM encoding and
// the helper that classifies an occupancy value into that encoding.
package branch_resolution_tracker_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    function automatic occ_state_t occ_state_of(input int occupancy, input int depth);
        occ_state_t state_s;
        if (occupancy == 32'sd0) begin
            state_s = OCC_EMPTY;
        end else if (occupancy >= depth) begin
            state_s = OCC_FULL;
        end else begin
            state_s = OCC_PARTIAL;
        end
        return state_s;
    endfunction

endpackage

// File: rtl/branch_resolution_tracker_fifo.sv
// In-order store of in-flight predictions {address, predicted} with push, pop
// and a flush that drops every queued entry (and any same-cycle push).
module branch_tracking_fifo
    import branch_resolution_tracker_pkg::*;
#(
    parameter int address_width = 1,
    parameter int depth         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [address_width-1:0] push_address,
    input  logic                     push_taken,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [address_width-1:0] head_address,
    output logic                     head_taken
);
    localparam int ptr_width = $clog2(depth);
    localparam logic [ptr_width-1:0] ptr_one = ptr_width'(1);
    localparam logic [ptr_width:0]   occ_one = (ptr_width + 1)'(1);

    logic [address_width-1:0] address_mem_r [depth];
    logic                     taken_mem_r   [depth];
    logic [ptr_width-1:0]     wr_ptr_r;
    logic [ptr_width-1:0]     rd_ptr_r;
    logic [ptr_width:0]       occupancy_r;
    logic [ptr_width:0]       occupancy_next_s;
    occ_state_t               state_r;
    occ_state_t               state_next_s;
    logic                     push_ok_s;
    logic                     pop_ok_s;

    assign push_ok_s    = push && !full;
    assign pop_ok_s     = pop && !empty;
    assign head_address = address_mem_r[rd_ptr_r];
    assign head_taken   = taken_mem_r[rd_ptr_r];

    // Entry storage; contents are meaningless until pointed to, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            address_mem_r[wr_ptr_r] <= push_address;
            taken_mem_r[wr_ptr_r]   <= push_taken;
        end
    end

    // Occupancy after this cycle's push/pop, ignoring flush.
    always_comb begin
        occupancy_next_s = occupancy_r;
        if (push_ok_s && !pop_ok_s) begin
            occupancy_next_s = occupancy_r + occ_one;
        end else if (!push_ok_s && pop_ok_s) begin
            occupancy_next_s = occupancy_r - occ_one;
        end else begin
            occupancy_next_s = occupancy_r;
        end
    end

    // Pointers and occupancy; flush leaves wr_ptr alone so a same-cycle push is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            occupancy_r <= '0;
        end else if (flush) begin
            rd_ptr_r    <= wr_ptr_r;
            occupancy_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_one;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_one;
            end
            occupancy_r <= occupancy_next_s;
        end
    end

    // Occupancy FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Occupancy FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY:   state_next_s = push_ok_s ? OCC_PARTIAL : OCC_EMPTY;
                OCC_PARTIAL: state_next_s = occ_state_of(32'(occupancy_next_s), depth);
                OCC_FULL:    state_next_s = pop_ok_s ? OCC_PARTIAL : OCC_FULL;
                default:     state_next_s = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy FSM outputs.
    always_comb begin
        full  = 1'b0;
        empty = 1'b0;
        case (state_r)
            OCC_EMPTY:   empty = 1'b1;
            OCC_PARTIAL: empty = 1'b0;
            OCC_FULL:    full  = 1'b1;
            default:     empty = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolution_tracker.sv
// Resolves queued branch predictions against execute outcomes, trains the
// predictor, pulses mispredict/resolve_error, and keeps saturating statistics.
module branch_resolution_tracker
    import branch_resolution_tracker_pkg::*;
#(
    parameter int address_width = 1,
    parameter int depth         = 4,
    parameter int count_width   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [address_width-1:0] pred_address,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     update_valid,
    output logic [address_width-1:0] update_address,
    output logic                     update_result,
    output logic                     mispredict,
    output logic                     resolve_error,
    output logic [count_width-1:0]   branch_count,
    output logic [count_width-1:0]   mispredict_count
);
    localparam logic [count_width-1:0] count_max = {count_width{1'b1}};
    localparam logic [count_width-1:0] count_one = count_width'(1);

    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [address_width-1:0] head_address_s;
    logic                     head_taken_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     mismatch_s;
    logic                     error_s;

    logic                     update_valid_r;
    logic [address_width-1:0] update_address_r;
    logic                     update_result_r;
    logic                     mispredict_r;
    logic                     resolve_error_r;
    logic [count_width-1:0]   branch_count_r;
    logic [count_width-1:0]   mispredict_count_r;

    assign pred_ready = !fifo_full_s;
    assign push_s     = pred_valid && !fifo_full_s;
    assign pop_s      = resolve_valid && !fifo_empty_s;
    assign mismatch_s = pop_s && (head_taken_s != resolve_taken);
    assign error_s    = resolve_valid && fifo_empty_s;

    branch_tracking_fifo #(
        .address_width (address_width),
        .depth         (depth)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push_s),
        .push_address (pred_address),
        .push_taken   (pred_taken),
        .pop          (pop_s),
        .flush        (mismatch_s),
        .full         (fifo_full_s),
        .empty        (fifo_empty_s),
        .head_address (head_address_s),
        .head_taken   (head_taken_s)
    );

    // Training port, one-cycle pulses and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            update_valid_r     <= 1'b0;
            update_address_r   <= '0;
            update_result_r    <= 1'b0;
            mispredict_r       <= 1'b0;
            resolve_error_r    <= 1'b0;
            branch_count_r     <= '0;
            mispredict_count_r <= '0;
        end else begin
            update_valid_r  <= pop_s;
            mispredict_r    <= mismatch_s;
            resolve_error_r <= error_s;
            if (pop_s) begin
                update_address_r <= head_address_s;
                update_result_r  <= resolve_taken;
            end
            if (pop_s && (branch_count_r != count_max)) begin
                branch_count_r <= branch_count_r + count_one;
            end
            if (mismatch_s && (mispredict_count_r != count_max)) begin
                mispredict_count_r <= mispredict_count_r + count_one;
            end
        end
    end

    assign update_valid     = update_valid_r;
    assign update_address   = update_address_r;
    assign update_result    = update_result_r;
    assign mispredict       = mispredict_r;
    assign resolve_error    = resolve_error_r;
    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule
